// File: rtl/dmem_block_mover_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_block_mover_if
//  Description : Data-memory port bundle. The master drives address, write
//                data and write enable; the slave (the memory) returns
//                combinational read data for the presented address.
//  Ports       : mem_addr  [31:0]  byte address (word aligned)
//                mem_wdata [31:0]  write data
//                mem_we            write enable, one word per cycle
//                mem_rdata [31:0]  read data for mem_addr
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_block_mover_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_block_mover.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_block_mover
//  Description : Data-memory bus initiator performing word block copy
//                (read source, write destination) or block fill (write a
//                constant), replacing the CPU on the data-memory port.
//  Ports       : clock, resetn       clock / synchronous active-low reset
//                i_start             request pulse, honoured in IDLE only
//                i_mode              0 = copy, 1 = fill
//                i_src_addr/dst_addr byte addresses, bits[1:0] dropped
//                i_len               word count (0 completes immediately)
//                i_fill_value        fill word
//                i_abort             cancel the running operation
//                mem                 data-memory port (master side)
//                o_busy/o_done       status / one-cycle completion pulse
//                o_words_done        words written by current/last operation
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_block_mover #(
    parameter int LEN_W  = 6,
    parameter int RD_LAT = 1
) (
    input  wire                 clock,
    input  wire                 resetn,
    input  wire                 i_start,
    input  wire                 i_mode,
    input  wire  [31:0]         i_src_addr,
    input  wire  [31:0]         i_dst_addr,
    input  wire  [LEN_W-1:0]    i_len,
    input  wire  [31:0]         i_fill_value,
    input  wire                 i_abort,
    dmem_block_mover_if.master  mem,
    output logic                o_busy,
    output logic                o_done,
    output logic [LEN_W-1:0]    o_words_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] c_WAIT_LAST = 2'(RD_LAT - 1);

    state_t            r_state;
    logic              r_mode;
    logic [31:0]       r_src;
    logic [31:0]       r_dst;
    logic [LEN_W-1:0]  r_rem;
    logic [LEN_W-1:0]  r_words;
    logic [1:0]        r_wait;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;   // doubles as the copy buffer

    logic [31:0]       w_src_next;
    logic [31:0]       w_dst_next;
    logic [31:0]       w_src_al;
    logic [31:0]       w_dst_al;

    assign w_src_next = r_src + 32'd4;
    assign w_dst_next = r_dst + 32'd4;
    assign w_src_al   = i_src_addr & ~32'd3;
    assign w_dst_al   = i_dst_addr & ~32'd3;

    // mem_addr / mem_wdata are loaded on the transition into the state that
    // uses them, so they are stable for the whole RD/WR cycle and simply
    // hold their last value once the block returns to IDLE.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_words <= '0;
            r_wait  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode  <= i_mode;
                        r_src   <= w_src_al;
                        r_dst   <= w_dst_al;
                        r_rem   <= i_len;
                        r_words <= '0;
                        r_wait  <= '0;
                        if (i_len == '0) begin
                            r_state <= S_DONE;
                        end else if (i_mode) begin
                            r_state <= S_WR;
                            r_addr  <= w_dst_al;
                            r_wdata <= i_fill_value;
                        end else begin
                            r_state <= S_RD;
                            r_addr  <= w_src_al;
                        end
                    end
                end

                S_RD: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_wdata <= mem.mem_rdata;
                        r_addr  <= r_dst;
                        r_wait  <= '0;
                        r_state <= S_WR;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end

                S_WR: begin
                    // The write on the bus this cycle always lands, even
                    // under abort, so it is always counted.
                    r_words <= r_words + 1'b1;
                    r_rem   <= r_rem - 1'b1;
                    r_dst   <= w_dst_next;
                    if (!r_mode) begin
                        r_src <= w_src_next;
                    end
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (r_rem == LEN_W'(1)) begin
                        r_state <= S_DONE;
                    end else if (r_mode) begin
                        r_addr <= w_dst_next;
                    end else begin
                        r_addr  <= w_src_next;
                        r_wait  <= '0;
                        r_state <= S_RD;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_we    = (r_state == S_WR);
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_words_done  = r_words;

endmodule
`default_nettype wire
